altro_bus_master: RTL

- Initiator side of the ALTRO-style front-end bus used between the readout controller and TRU/FEE slaves.
- Converts single register requests (write, read, CHRDO channel-readout command) into cstb/write/bd cycles and waits for the slave's ackn.
- For CHRDO it hands the bus to the slave and collects the 40-bit words strobed out under trsf/dstb.
- Sits in the board controller between the command decoder (request side) and the bus pad drivers.

---
 rtl/altro_bus_pkg.sv | 55 +++++
 rtl/altro_bus_master_if.sv | 47 ++++
 rtl/altro_timeout_cnt.sv | 32 +++
 rtl/altro_bus_master.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/altro_bus_pkg.sv
// Shared definitions for the ALTRO-style front-end bus (master and slave side).
// Holds state encoding, command codes, bd field positions and response codes.
package altro_bus_pkg;

    localparam int BD_W   = 40;
    localparam int DATA_W = 20;
    localparam int TMO_W  = 16;

    localparam logic [4:0] CHRDO_CODE = 5'h1A;

    // bd field positions
    localparam int BD_PAR     = 39;
    localparam int BD_BRANCH  = 36;
    localparam int BD_CHIP_HI = 31;
    localparam int BD_CHIP_LO = 29;
    localparam int BD_CHAN_HI = 28;
    localparam int BD_CHAN_LO = 25;
    localparam int BD_REG_HI  = 24;
    localparam int BD_REG_LO  = 20;
    localparam int BD_DATA_HI = 19;

    localparam logic [1:0] ERR_OK   = 2'd0;
    localparam logic [1:0] ERR_ACK  = 2'd1;
    localparam logic [1:0] ERR_TRSF = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SETUP     = 3'd1,
        ST_STROBE    = 3'd2,
        ST_RELEASE   = 3'd3,
        ST_WAIT_TRSF = 3'd4,
        ST_READOUT   = 3'd5,
        ST_DONE      = 3'd6
    } state_t;

    // Assemble a bus command word; bit 39 is even parity over bd[38:20].
    function automatic logic [BD_W-1:0] build_bd(
        input logic        branch,
        input logic [2:0]  chip,
        input logic [3:0]  chan,
        input logic [4:0]  regc,
        input logic [19:0] data
    );
        logic [BD_W-1:0] w;
        w                          = '0;
        w[BD_BRANCH]               = branch;
        w[BD_CHIP_HI:BD_CHIP_LO]   = chip;
        w[BD_CHAN_HI:BD_CHAN_LO]   = chan;
        w[BD_REG_HI:BD_REG_LO]     = regc;
        w[BD_DATA_HI:0]            = data;
        w[BD_PAR]                  = ^w[BD_PAR-1:BD_REG_LO];
        return w;
    endfunction

endpackage

// File: rtl/altro_bus_master_if.sv
// Request/response and bus-pad signals of the ALTRO bus master.
// master modport: the initiator's view; slave modport: the counterpart view
// (command decoder, pad drivers and the bus slave together).
interface altro_bus_master_if;
    import altro_bus_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic              req_branch;
    logic [2:0]        req_chip;
    logic [3:0]        req_chan;
    logic [4:0]        req_reg;
    logic [DATA_W-1:0] req_data;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic [1:0]        rsp_err;
    logic              ro_valid;
    logic [BD_W-1:0]   ro_data;
    logic [15:0]       ro_count;
    logic [BD_W-1:0]   bd_in;
    logic [BD_W-1:0]   bd_out;
    logic              bd_oe_h;
    logic              bd_oe_l;
    logic              cstb_n;
    logic              write;
    logic              ackn_n;
    logic              trsf;
    logic              dstb_n;

    modport master (
        input  req_valid, req_write, req_branch, req_chip, req_chan, req_reg, req_data,
        input  bd_in, ackn_n, trsf, dstb_n,
        output req_ready, rsp_valid, rsp_data, rsp_err,
        output ro_valid, ro_data, ro_count,
        output bd_out, bd_oe_h, bd_oe_l, cstb_n, write
    );

    modport slave (
        output req_valid, req_write, req_branch, req_chip, req_chan, req_reg, req_data,
        output bd_in, ackn_n, trsf, dstb_n,
        input  req_ready, rsp_valid, rsp_data, rsp_err,
        input  ro_valid, ro_data, ro_count,
        input  bd_out, bd_oe_h, bd_oe_l, cstb_n, write
    );

endinterface

// File: rtl/altro_timeout_cnt.sv
// Loadable down-counter with terminal-count flag, shared by the setup,
// ackn and trsf waits.
// Ports: rclk, reset (sync, active high), i_load/i_load_val (load has priority),
//        i_dec (decrement, holds at zero), o_expired (count == 0).
module altro_timeout_cnt
    import altro_bus_pkg::*;
#(
    parameter int W = TMO_W
) (
    input  logic         rclk,
    input  logic         reset,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_expired
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge rclk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/altro_bus_master.sv
// Initiator side of the ALTRO front-end bus: turns single write/read/CHRDO
// requests into cstb/write/bd cycles and collects readout words afterwards.
// Ports: rclk, reset (sync, active high), bus (master modport: request,
//        response, readout and pad signals).
//
// state     | meaning
// IDLE      | req_ready high, waiting for a request
// SETUP     | bd/write driven, cstb_n still high
// STROBE    | cstb_n low, waiting for ackn_n low
// RELEASE   | cstb_n high, bus driven, waiting for ackn_n high
// WAIT_TRSF | bus released after CHRDO, waiting for trsf rise
// READOUT   | capturing words on dstb_n until trsf falls
// DONE      | one-cycle rsp_valid
module altro_bus_master #(
    parameter int unsigned SETUP_CYCLES = 1,
    parameter int unsigned ACK_TIMEOUT  = 32,
    parameter int unsigned TRSF_TIMEOUT = 1024,
    parameter logic [4:0]  CHRDO_CODE   = altro_bus_pkg::CHRDO_CODE
) (
    input logic                rclk,
    input logic                reset,
    altro_bus_master_if.master bus
);
    import altro_bus_pkg::*;

    // Counter is loaded with N-1 so that each wait lasts exactly N cycles.
    localparam logic [TMO_W-1:0] LD_SETUP = TMO_W'(SETUP_CYCLES - 1);
    localparam logic [TMO_W-1:0] LD_ACK   = TMO_W'(ACK_TIMEOUT - 1);
    localparam logic [TMO_W-1:0] LD_TRSF  = TMO_W'(TRSF_TIMEOUT - 1);

    state_t            r_state;
    state_t            w_next;
    logic              r_write;
    logic [4:0]        r_reg;
    logic [BD_W-1:0]   r_word;
    logic [DATA_W-1:0] r_rsp_data;
    logic [1:0]        r_rsp_err;
    logic              r_trsf_q;
    logic              r_ro_valid;
    logic [BD_W-1:0]   r_ro_data;
    logic [15:0]       r_ro_count;

    logic              w_accept;
    logic              w_load;
    logic [TMO_W-1:0]  w_load_val;
    logic              w_dec;
    logic              w_expired;
    logic              w_err_set;
    logic [1:0]        w_err_val;
    logic              w_cap_rd;
    logic              w_capture;
    logic              w_drive;

    altro_timeout_cnt #(.W(TMO_W)) u_tmo (
        .rclk       (rclk),
        .reset      (reset),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_dec      (w_dec),
        .o_expired  (w_expired)
    );

    assign w_accept  = bus.req_valid && (r_state == ST_IDLE);
    assign w_capture = (r_state == ST_READOUT) && bus.trsf && !bus.dstb_n;
    assign w_drive   = (r_state == ST_SETUP) || (r_state == ST_STROBE) ||
                       (r_state == ST_RELEASE);

    always_comb begin
        w_next     = r_state;
        w_load     = 1'b0;
        w_load_val = '0;
        w_dec      = 1'b0;
        w_err_set  = 1'b0;
        w_err_val  = ERR_OK;
        w_cap_rd   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next     = ST_SETUP;
                    w_load     = 1'b1;
                    w_load_val = LD_SETUP;
                end
            end
            ST_SETUP: begin
                if (w_expired) begin
                    w_next     = ST_STROBE;
                    w_load     = 1'b1;
                    w_load_val = LD_ACK;
                end else begin
                    w_dec = 1'b1;
                end
            end
            ST_STROBE: begin
                // Acknowledge wins over an expiry in the same cycle.
                if (!bus.ackn_n) begin
                    w_next     = ST_RELEASE;
                    w_load     = 1'b1;
                    w_load_val = LD_ACK;
                    w_cap_rd   = !r_write;
                end else if (w_expired) begin
                    w_next    = ST_DONE;
                    w_err_set = 1'b1;
                    w_err_val = ERR_ACK;
                end else begin
                    w_dec = 1'b1;
                end
            end
            ST_RELEASE: begin
                if (bus.ackn_n) begin
                    if (r_write && (r_reg == CHRDO_CODE)) begin
                        w_next     = ST_WAIT_TRSF;
                        w_load     = 1'b1;
                        w_load_val = LD_TRSF;
                    end else begin
                        w_next = ST_DONE;
                    end
                end else if (w_expired) begin
                    w_next    = ST_DONE;
                    w_err_set = 1'b1;
                    w_err_val = ERR_ACK;
                end else begin
                    w_dec = 1'b1;
                end
            end
            ST_WAIT_TRSF: begin
                if (bus.trsf && !r_trsf_q) begin
                    w_next = ST_READOUT;
                end else if (w_expired) begin
                    w_next    = ST_DONE;
                    w_err_set = 1'b1;
                    w_err_val = ERR_TRSF;
                end else begin
                    w_dec = 1'b1;
                end
            end
            ST_READOUT: begin
                if (!bus.trsf && r_trsf_q) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge rclk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_write    <= 1'b0;
            r_reg      <= '0;
            r_word     <= '0;
            r_rsp_data <= '0;
            r_rsp_err  <= ERR_OK;
            r_trsf_q   <= 1'b0;
            r_ro_valid <= 1'b0;
            r_ro_data  <= '0;
            r_ro_count <= '0;
        end else begin
            r_state    <= w_next;
            r_trsf_q   <= bus.trsf;
            r_ro_valid <= w_capture;
            if (w_accept) begin
                r_write    <= bus.req_write;
                r_reg      <= bus.req_reg;
                // Data field is only meaningful (and only driven) for writes.
                r_word     <= build_bd(bus.req_branch, bus.req_chip, bus.req_chan,
                                       bus.req_reg, bus.req_write ? bus.req_data : '0);
                r_rsp_data <= '0;
                r_rsp_err  <= ERR_OK;
            end
            if (w_cap_rd) begin
                r_rsp_data <= bus.bd_in[DATA_W-1:0];
            end
            if (w_err_set) begin
                r_rsp_err <= w_err_val;
            end
            if (r_state == ST_WAIT_TRSF) begin
                r_ro_count <= '0;
            end
            if (w_capture) begin
                r_ro_data <= bus.bd_in;
                if (r_ro_count != 16'hFFFF) begin
                    r_ro_count <= r_ro_count + 16'd1;
                end
            end
        end
    end

    assign bus.req_ready = (r_state == ST_IDLE);
    assign bus.rsp_valid = (r_state == ST_DONE);
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.ro_valid  = r_ro_valid;
    assign bus.ro_data   = r_ro_data;
    assign bus.ro_count  = r_ro_count;
    assign bus.cstb_n    = (r_state != ST_STROBE);
    assign bus.write     = w_drive ? !r_write : 1'b1;
    assign bus.bd_oe_h   = w_drive;
    assign bus.bd_oe_l   = w_drive && r_write;
    assign bus.bd_out    = w_drive ? r_word : '0;

endmodule
